// File: rtl/shift_scheduler.sv
// Round-robin scheduler for the shared barrel shifter.
// Splits each shift amount into passes of at most MAX_STEP.
module shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int LW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] dbl;
  logic [LW-1:0]      rot;

  // One combinational pass of LSL/LSR/ASR/RR
  always_comb begin
    rot  = shamt[LW-1:0];
    dbl  = {din, din} >> rot;
    dout = din;
    unique case (op)
      2'b00: dout = din << shamt;
      2'b01: dout = din >> shamt;
      2'b10: dout = $signed(din) >>> shamt;
      2'b11: dout = dbl[WIDTH-1:0];
      default: dout = din;
    endcase
  end
endmodule

module shift_scheduler #(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [7:0]       req0_amt,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [7:0]       req1_amt,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [5:0]       rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             prio_q, prio_d;
  logic             rsp_valid_q;
  logic             busy_q;

  logic             g0, g1;
  logic [1:0]       sel_op;
  logic [7:0]       sel_amt;
  logic [WIDTH-1:0] sel_data;
  logic [5:0]       cnt;
  logic [4:0]       step;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] sh_out;

  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .op    (op_q),
    .shamt (shamt),
    .din   (acc_q),
    .dout  (sh_out)
  );

  // Grant: a lone requester wins, a tie goes to the favoured one
  always_comb begin
    g0 = req0_valid & (~req1_valid | ~prio_q);
    g1 = req1_valid & (~req0_valid | prio_q);
    req0_ready = rst_n & (state_q == IDLE) & g0;
    req1_ready = rst_n & (state_q == IDLE) & g1;
  end

  // Job selection, remaining count and per-pass step
  always_comb begin
    sel_op   = g1 ? req1_op   : req0_op;
    sel_amt  = g1 ? req1_amt  : req0_amt;
    sel_data = g1 ? req1_data : req0_data;
    if (sel_op == 2'b11)
      cnt = 6'(sel_amt & 8'(WIDTH - 1));
    else if (sel_amt >= 8'(WIDTH))
      cnt = 6'(WIDTH);
    else
      cnt = sel_amt[5:0];
    if (rem_q > 6'(MAX_STEP))
      step = 5'(MAX_STEP);
    else
      step = rem_q[4:0];
    shamt = (state_q == SHIFT) ? step : 5'd0;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    id_d    = id_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          op_d    = sel_op;
          acc_d   = sel_data;
          id_d    = req1_ready;
          rem_d   = cnt;
          prio_d  = ~req1_ready;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = sh_out;
        rem_d = rem_q - 6'(step);
        if (rem_d == 6'd0)
          state_d = DONE;
      end
      DONE: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      op_q        <= op_d;
      id_q        <= id_d;
      prio_q      <= prio_d;
      rsp_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = acc_q;
  assign busy      = busy_q;
endmodule
